main_mem_responder: RTL and testbench



---
 rtl/main_mem_pkg.sv | 25 ++
 rtl/main_mem_array.sv | 25 ++
 rtl/main_mem_responder.sv | 124 ++++++++++++
 tb/tb_main_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared types and constants for the cache-to-RAM memory responder.
// State and op encodings are fixed so they read the same in waveforms across the codebase.
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int LAT_CNT_W  = 4;
    localparam int DEF_RD_LAT = 3;
    localparam int DEF_WR_LAT = 2;

    // Counter preload: the completion edge is the one where the counter reads zero.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
        return LAT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// Word-addressed single-port main memory: synchronous write, combinational read.
// The read port feeds a register in the responder, so no output flop is needed here.
module main_mem_array #(
    parameter int DEPTH_W = 10,
    parameter int DATA_W  = 32
) (
    input  logic               iCLK,
    input  logic               we,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_W];

    // NOTE: storage has no reset; contents must survive a responder reset.
    always_ff @(posedge iCLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder for the cache memory port: latches one request, waits a
// programmable latency, performs it on the backing array and pulses ready for one cycle.
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 10,
    parameter int RD_LAT  = DEF_RD_LAT,
    parameter int WR_LAT  = DEF_WR_LAT
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [ADDR_W-1:0] cache2mem_addr,
    input  logic [DATA_W-1:0] cache2mem_data,
    input  logic              cache2mem_MemWrite,
    input  logic              cache2mem_MemRead,
    output logic [DATA_W-1:0] mem2cache_data_in,
    output logic              mem2cache_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    state_t                 state;
    state_t                 state_next;
    logic [LAT_CNT_W-1:0]   cnt;
    logic [DEPTH_W-1:0]     lat_idx;
    logic [DATA_W-1:0]      lat_data;
    op_t                    lat_op;
    logic                   lat_ok;

    logic                   req;
    logic                   req_ok;
    op_t                    req_op;
    logic                   accept;
    logic                   complete;
    logic                   ram_we;
    logic [DATA_W-1:0]      ram_rdata;
    logic                   unused_addr_bits;

    assign req              = cache2mem_MemWrite | cache2mem_MemRead;
    assign req_ok           = (cache2mem_addr[ADDR_W-1:DEPTH_W+2] == '0);
    assign req_op           = cache2mem_MemWrite ? OP_WR : OP_RD;
    assign unused_addr_bits = ^cache2mem_addr[1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = BUSY;
            BUSY:    if (cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        complete = 1'b0;
        ram_we   = 1'b0;
        case (state)
            IDLE: accept = req;
            BUSY: begin
                complete = (cnt == '0);
                ram_we   = complete && (lat_op == OP_WR) && lat_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cnt               <= '0;
            lat_idx           <= '0;
            lat_data          <= '0;
            lat_op            <= OP_RD;
            lat_ok            <= 1'b0;
            mem2cache_data_in <= '0;
            mem_err           <= 1'b0;
        end else begin
            if (accept) begin
                lat_idx  <= cache2mem_addr[DEPTH_W+1:2];
                lat_data <= cache2mem_data;
                lat_op   <= req_op;
                lat_ok   <= req_ok;
                cnt      <= (req_op == OP_WR) ? lat_load(WR_LAT) : lat_load(RD_LAT);
                // Conflicting ops and unmapped addresses are both flagged at acceptance.
                if ((cache2mem_MemWrite && cache2mem_MemRead) || !req_ok) begin
                    mem_err <= 1'b1;
                end
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (complete && lat_op == OP_RD) begin
                mem2cache_data_in <= lat_ok ? ram_rdata : '0;
            end
        end
    end

    assign mem2cache_ready = (state == RESP);
    assign mem_busy        = (state != IDLE);

    main_mem_array #(
        .DEPTH_W (DEPTH_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .iCLK  (iCLK),
        .we    (ram_we),
        .addr  (lat_idx),
        .wdata (lat_data),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a word-array reference model.
module tb_main_mem_responder;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic [31:0] cache2mem_addr;
    logic [31:0] cache2mem_data;
    logic        cache2mem_MemWrite;
    logic        cache2mem_MemRead;
    logic [31:0] mem2cache_data_in;
    logic        mem2cache_ready;
    logic        mem_busy;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 iCLK = ~iCLK;

    main_mem_responder dut (
        .iCLK               (iCLK),
        .iRST_n             (iRST_n),
        .cache2mem_addr     (cache2mem_addr),
        .cache2mem_data     (cache2mem_data),
        .cache2mem_MemWrite (cache2mem_MemWrite),
        .cache2mem_MemRead  (cache2mem_MemRead),
        .mem2cache_data_in  (mem2cache_data_in),
        .mem2cache_ready    (mem2cache_ready),
        .mem_busy           (mem_busy),
        .mem_err            (mem_err)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        cache2mem_MemWrite = 1'b0;
        cache2mem_MemRead  = 1'b0;
        cache2mem_addr     = '0;
        cache2mem_data     = '0;
    endtask

    // Present a request before an edge; returns 1ns after the acceptance edge.
    task automatic start_req(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wdata);
        @(negedge iCLK);
        cache2mem_MemWrite = wr;
        cache2mem_MemRead  = rd;
        cache2mem_addr     = addr;
        cache2mem_data     = wdata;
        @(posedge iCLK);
        #1;
    endtask

    // Counts edges after acceptance until ready is seen; -1 when the budget expires.
    task automatic wait_ready(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge iCLK);
            #1;
            if (mem2cache_ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic txn(input string name, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic drop_mid,
                       input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
        int lat;
        start_req(wr, rd, addr, wdata);
        check({name, " busy"}, 32'(mem_busy), 32'd1);
        if (drop_mid) idle_inputs();
        wait_ready(lat);
        check({name, " lat"}, 32'(lat), 32'(exp_lat));
        check({name, " data"}, mem2cache_data_in, exp_data);
        check({name, " err"}, 32'(mem_err), 32'(exp_err));
        idle_inputs();
        @(posedge iCLK);
        #1;
        check({name, " idle"}, {30'd0, mem_busy, mem2cache_ready}, 32'd0);
    endtask

    vec_t        vecs [11];
    logic [31:0] model_mem [64];
    logic [31:0] model_last;
    logic        model_err;
    int          lat;
    int          seen_ready;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h40,  32'hDEADBEEF, WR_LAT, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h40,  32'h0,        RD_LAT, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h00,  32'hCAFEF00D, WR_LAT, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h08,  32'h00000005, WR_LAT, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h04,  32'h22222222, WR_LAT, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h20,  32'h00001234, WR_LAT, 32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h43,  32'h0,        RD_LAT, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h00,  32'h0,        RD_LAT, 32'hCAFEF00D, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFC, 32'h0BADF00D, WR_LAT, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFC, 32'h0,        RD_LAT, 32'h0BADF00D, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0C,  32'h00000099, WR_LAT, 32'h0BADF00D, 1'b0};

        iRST_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge iCLK);
        #1;
        check("reset ready", 32'(mem2cache_ready), 32'd0);
        check("reset busy",  32'(mem_busy),        32'd0);
        check("reset err",   32'(mem_err),         32'd0);
        check("reset data",  mem2cache_data_in,    32'd0);
        @(negedge iCLK);
        iRST_n = 1'b1;

        foreach (vecs[i]) begin
            txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                1'b0, vecs[i].exp_lat, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Write-back, then switch to the allocate read during the ready cycle.
        start_req(1'b1, 1'b0, 32'h84, 32'h11111111);
        wait_ready(lat);
        check("wb lat", 32'(lat), 32'(WR_LAT));
        cache2mem_MemWrite = 1'b0;
        cache2mem_MemRead  = 1'b1;
        cache2mem_addr     = 32'h04;
        @(posedge iCLK);
        #1;
        check("alloc not yet", {30'd0, mem_busy, mem2cache_ready}, 32'd0);
        @(posedge iCLK);
        #1;
        check("alloc accepted", 32'(mem_busy), 32'd1);
        wait_ready(lat);
        check("alloc lat", 32'(lat), 32'(RD_LAT));
        check("alloc data", mem2cache_data_in, 32'h22222222);
        idle_inputs();
        @(posedge iCLK);
        #1;
        txn("wb readback", 1'b0, 1'b1, 32'h84, 32'h0, 1'b0, RD_LAT, 32'h11111111, 1'b0);

        // Address moves during BUSY; the latched address must be used.
        start_req(1'b0, 1'b1, 32'h08, 32'h0);
        cache2mem_addr = 32'h0C;
        wait_ready(lat);
        check("latched lat", 32'(lat), 32'(RD_LAT));
        check("latched data", mem2cache_data_in, 32'h00000005);
        idle_inputs();
        @(posedge iCLK);
        #1;

        // Reset during a pending write.
        start_req(1'b1, 1'b0, 32'h20, 32'h00000077);
        #2;
        iRST_n = 1'b0;
        idle_inputs();
        #1;
        check("rst mid busy",  32'(mem_busy),        32'd0);
        check("rst mid ready", 32'(mem2cache_ready), 32'd0);
        check("rst mid data",  mem2cache_data_in,    32'd0);
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRST_n = 1'b1;
        seen_ready = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge iCLK);
            #1;
            if (mem2cache_ready || mem_busy) seen_ready++;
        end
        check("rst no pulse", 32'(seen_ready), 32'd0);
        txn("rst old value", 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, RD_LAT, 32'h00001234, 1'b0);

        // Simultaneous read and write: write wins, error latches, read data untouched.
        txn("rw both", 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, WR_LAT, 32'h00001234, 1'b1);
        txn("rw readback", 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, RD_LAT, 32'hA5A5A5A5, 1'b1);

        // Out-of-range address aliases onto word 0 if the range check is broken.
        txn("oor read", 1'b0, 1'b1, 32'h00001000, 32'h0, 1'b0, RD_LAT, 32'h0, 1'b1);
        txn("oor write", 1'b1, 1'b0, 32'h00001000, 32'hBADBAD00, 1'b0, WR_LAT, 32'h0, 1'b1);
        txn("oor intact", 1'b0, 1'b1, 32'h00000000, 32'h0, 1'b0, RD_LAT, 32'hCAFEF00D, 1'b1);

        // Randomized traffic over words 0..63 against an array model.
        model_last = 32'hCAFEF00D;
        model_err  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = $urandom;
            txn("preload", 1'b1, 1'b0, 32'(i * 4), model_mem[i], 1'b0, WR_LAT, model_last,
                model_err);
        end
        for (int i = 0; i < 80; i++) begin
            int          sel;
            int          idx;
            logic        wr;
            logic        rd;
            logic        oor;
            logic [19:0] upper;
            logic [31:0] addr;
            logic [31:0] wdata;
            sel   = int'($urandom_range(0, 9));
            wr    = (sel < 4) || (sel == 9);
            rd    = (sel >= 4);
            idx   = int'($urandom_range(0, 63));
            oor   = ($urandom_range(0, 7) == 0);
            upper = oor ? 20'($urandom_range(1, 20'hFFFFF)) : 20'd0;
            addr  = {upper, 10'(idx), 2'($urandom)};
            wdata = $urandom;
            if (wr) begin
                if (!oor) model_mem[idx] = wdata;
            end else begin
                model_last = oor ? 32'd0 : model_mem[idx];
            end
            if ((wr && rd) || oor) model_err = 1'b1;
            txn($sformatf("rand%0d", i), wr, rd, addr, wdata, 1'($urandom_range(0, 1)),
                wr ? WR_LAT : RD_LAT, model_last, model_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
